// File: rtl/mem_dma_initiator.sv
// mem_dma_initiator: bus-master that copies or fills a block of data-memory words.
module mem_dma_initiator #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  remaining
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  logic [1:0]        state, nxt;
  logic [ADDR_W-1:0] src, dst, src_n, dst_n;
  logic [LEN_W-1:0]  rem_n;
  logic [DATA_W-1:0] data_r, fill_r, data_n, fill_n;
  logic              mode_r, mode_n, abt;
  always_comb begin
    nxt    = state;
    src_n  = src;
    dst_n  = dst;
    rem_n  = remaining;
    mode_n = mode_r;
    fill_n = fill_r;
    data_n = data_r;
    abt    = 1'b0;
    if (state == S_IDLE || state == S_DONE) begin
      nxt = S_IDLE;
      if (start) begin
        src_n  = src_addr;
        dst_n  = dst_addr;
        rem_n  = length;
        mode_n = mode;
        fill_n = fill_data;
        nxt    = (length == '0) ? S_DONE : mode ? S_WRITE : S_READ;
      end
    end else if (state == S_READ) begin
      data_n = mem_rdata;
      src_n  = src + 1'b1;
      abt    = abort;
      nxt    = abort ? S_IDLE : S_WRITE;
    end else begin
      // the write already on the bus this cycle always completes, even on abort
      dst_n = dst + 1'b1;
      rem_n = remaining - 1'b1;
      abt   = abort;
      nxt   = abort ? S_IDLE : (remaining == 1) ? S_DONE : mode_r ? S_WRITE : S_READ;
    end
  end
  // memory-side outputs are registered from the next state so start never reaches them combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      mode_r    <= 1'b0;
      fill_r    <= '0;
      data_r    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= nxt;
      src       <= src_n;
      dst       <= dst_n;
      remaining <= rem_n;
      mode_r    <= mode_n;
      fill_r    <= fill_n;
      data_r    <= data_n;
      mem_addr  <= (nxt == S_READ) ? src_n : (nxt == S_WRITE) ? dst_n : mem_addr;
      mem_wdata <= (nxt == S_WRITE) ? (mode_n ? fill_n : data_n) : mem_wdata;
      mem_we    <= nxt == S_WRITE;
      mem_re    <= nxt == S_READ;
      done      <= nxt == S_DONE;
      aborted   <= abt;
    end
  end
  assign busy = state == S_READ || state == S_WRITE;
endmodule
